// File: rtl/divider.sv
// divider: 32-bit restoring divider, one quotient bit per cycle, with {N,Z,C,V} result flags.
// Define DIVIDER_SIGNED_EN for two's-complement operands; otherwise operands are unsigned.
`default_nettype none

module divider (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Start,
    input  logic [31:0] In1,
    input  logic [31:0] In2,
    input  logic        S,
    output logic [31:0] Quot,
    output logic [31:0] Rem,
    output logic        Busy,
    output logic        Done,
    output logic [3:0]  Flags
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [31:0] r_q;
    logic [31:0] r_d;
    logic [32:0] r_r;
    logic        r_qneg;
    logic        r_rneg;
    logic        r_v;
    logic        r_s;

    logic        w_a_neg;
    logic        w_b_neg;
    logic        w_ovf;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic        w_ge;
    logic [31:0] w_q_res;
    logic [31:0] w_r_res;

`ifdef DIVIDER_SIGNED_EN
    assign w_a_neg = In1[31];
    assign w_b_neg = In2[31];
    assign w_ovf   = (In1 == 32'h8000_0000) && (In2 == 32'hFFFF_FFFF);
`else
    assign w_a_neg = 1'b0;
    assign w_b_neg = 1'b0;
    assign w_ovf   = 1'b0;
`endif

    assign w_a_mag = w_a_neg ? (~In1 + 32'd1) : In1;
    assign w_b_mag = w_b_neg ? (~In2 + 32'd1) : In2;

    // Bring the next dividend bit into the partial remainder and trial-subtract.
    assign w_shift = {r_r[31:0], r_q[31]};
    assign w_ge    = (w_shift >= {1'b0, r_d});
    assign w_diff  = w_shift - {1'b0, r_d};

    assign w_q_res = r_qneg ? (~r_q + 32'd1) : r_q;
    assign w_r_res = r_rneg ? (~r_r[31:0] + 32'd1) : r_r[31:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= 5'd0;
            r_q     <= 32'd0;
            r_d     <= 32'd0;
            r_r     <= 33'd0;
            r_qneg  <= 1'b0;
            r_rneg  <= 1'b0;
            r_v     <= 1'b0;
            r_s     <= 1'b0;
            Quot    <= 32'd0;
            Rem     <= 32'd0;
            Flags   <= 4'd0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Busy still covers the Done cycle, so a Start there is ignored.
                    if (Busy) begin
                        Busy <= 1'b0;
                    end else if (Start) begin
                        Busy   <= 1'b1;
                        r_s    <= S;
                        r_d    <= w_b_mag;
                        r_cnt  <= 5'd0;
                        if (In2 == 32'd0) begin
                            r_q     <= 32'hFFFF_FFFF;
                            r_r     <= {1'b0, In1};
                            r_qneg  <= 1'b0;
                            r_rneg  <= 1'b0;
                            r_v     <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_q     <= w_a_mag;
                            r_r     <= 33'd0;
                            r_qneg  <= w_a_neg ^ w_b_neg;
                            r_rneg  <= w_a_neg;
                            r_v     <= w_ovf;
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    r_r <= w_ge ? w_diff : w_shift;
                    r_q <= {r_q[30:0], w_ge};
                    if (r_cnt == 5'd31) begin
                        r_cnt   <= 5'd0;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                DONE: begin
                    Done    <= 1'b1;
                    Quot    <= w_q_res;
                    Rem     <= w_r_res;
                    Flags   <= r_s ? {w_q_res[31], (w_q_res == 32'd0), (|r_r), r_v} : 4'b0000;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_divider.sv
// tb_divider: directed and random checks of divider against a scoreboard of expected results.
`default_nettype none

module tb_divider;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Start = 1'b0;
    logic        S = 1'b0;
    logic [31:0] In1 = 32'd0;
    logic [31:0] In2 = 32'd0;
    logic [31:0] Quot;
    logic [31:0] Rem;
    logic        Busy;
    logic        Done;
    logic [3:0]  Flags;

    divider dut (
        .clk   (clk),
        .rst_n (rst_n),
        .Start (Start),
        .In1   (In1),
        .In2   (In2),
        .S     (S),
        .Quot  (Quot),
        .Rem   (Rem),
        .Busy  (Busy),
        .Done  (Done),
        .Flags (Flags)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic [3:0]  f;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
        exp_t        e;
        logic [31:0] q;
        logic [31:0] r;
        logic        v;
        v = 1'b0;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            v = 1'b1;
        end
`ifdef DIVIDER_SIGNED_EN
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
            v = 1'b1;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
`else
        else begin
            q = a / b;
            r = a % b;
        end
`endif
        e.q = q;
        e.r = r;
        e.f = s ? {q[31], (q == 32'd0), (r != 32'd0), v} : 4'b0000;
        return e;
    endfunction

    task automatic wait_done(output int n);
        n = 0;
        while (Done !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic check_result(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_underflow"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_quot"}, Quot, e.q);
            chk({tag, "_rem"}, Rem, e.r);
            chk({tag, "_flags"}, {28'd0, Flags}, {28'd0, e.f});
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input exp_t e);
        int n;
        @(negedge clk);
        In1 = a;
        In2 = b;
        S = s;
        Start = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        Start = 1'b0;
        In1 = $urandom;
        In2 = $urandom;
        S = ~s;
        chk({tag, "_busy"}, {31'd0, Busy}, 32'd1);
        wait_done(n);
        chk({tag, "_latency"}, n, (b == 32'd0) ? 32'd1 : 32'd33);
        check_result(tag);
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, {31'd0, Done}, 32'd0);
        chk({tag, "_busy_clear"}, {31'd0, Busy}, 32'd0);
        chk({tag, "_hold_quot"}, Quot, e.q);
    endtask

    initial begin
        int          n;
        int          dn;
        logic [31:0] a;
        logic [31:0] b;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_quot", Quot, 32'd0);
        chk("rst_rem", Rem, 32'd0);
        chk("rst_flags", {28'd0, Flags}, 32'd0);
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_done", {31'd0, Done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("d100_7", 32'd100, 32'd7, 1'b1, '{q: 32'd14, r: 32'd2, f: 4'b0010});
        run_op("d7_7_s0", 32'd7, 32'd7, 1'b0, '{q: 32'd1, r: 32'd0, f: 4'b0000});
        run_op("d5_0", 32'd5, 32'd0, 1'b1, '{q: 32'hFFFF_FFFF, r: 32'd5, f: 4'b1011});
`ifdef DIVIDER_SIGNED_EN
        run_op("dm100_7", 32'hFFFF_FF9C, 32'd7, 1'b1,
               '{q: 32'hFFFF_FFF2, r: 32'hFFFF_FFFE, f: 4'b1010});
        run_op("dovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1,
               '{q: 32'h8000_0000, r: 32'd0, f: 4'b1001});
`else
        run_op("dbig_7", 32'hFFFF_FF9C, 32'd7, 1'b1, model(32'hFFFF_FF9C, 32'd7, 1'b1));
        run_op("d8000_ffff", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1,
               '{q: 32'd0, r: 32'h8000_0000, f: 4'b0110});
`endif
        run_op("dmax_1", 32'hFFFF_FFFF, 32'd1, 1'b1, model(32'hFFFF_FFFF, 32'd1, 1'b1));
        run_op("d0_5", 32'd0, 32'd5, 1'b1, model(32'd0, 32'd5, 1'b1));
        for (int i = 0; i < 4; i++) begin
            a = $urandom;
            b = (i < 2) ? 32'($urandom_range(1, 1000)) : $urandom;
            if (b == 32'd0) b = 32'd3;
            run_op("drand", a, b, 1'b1, model(a, b, 1'b1));
        end

        // A second Start during the operation must not disturb the captured operands.
        @(negedge clk);
        In1 = 32'd9; In2 = 32'd3; S = 1'b1; Start = 1'b1;
        sb.push_back(model(32'd9, 32'd3, 1'b1));
        @(posedge clk);
        #1;
        Start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        In1 = 32'd8; In2 = 32'd2; Start = 1'b1;
        @(posedge clk);
        #1;
        Start = 1'b0;
        chk("ign_busy", {31'd0, Busy}, 32'd1);
        wait_done(n);
        chk("ign_latency", n, 32'd23);
        check_result("ign");
        @(posedge clk);
        #1;
        chk("ign_done_pulse", {31'd0, Done}, 32'd0);
        chk("ign_sb_empty", sb.size(), 32'd0);

        // Abort mid-operation with an asynchronous reset between clock edges.
        @(negedge clk);
        In1 = 32'd9; In2 = 32'd3; S = 1'b1; Start = 1'b1;
        @(posedge clk);
        #1;
        Start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        In1 = 32'd8; In2 = 32'd2; Start = 1'b1;
        @(posedge clk);
        #1;
        Start = 1'b0;
        repeat (9) @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, Busy}, 32'd0);
        chk("abort_done", {31'd0, Done}, 32'd0);
        chk("abort_quot", Quot, 32'd0);
        chk("abort_rem", Rem, 32'd0);
        chk("abort_flags", {28'd0, Flags}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (Done === 1'b1) dn++;
        end
        chk("abort_no_done", dn, 32'd0);

        // Start presented on the first edge after reset release.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        In1 = 32'd100; In2 = 32'd7; S = 1'b1; Start = 1'b1;
        sb.push_back('{q: 32'd14, r: 32'd2, f: 4'b0010});
        @(posedge clk);
        #1;
        Start = 1'b0;
        chk("first_edge_busy", {31'd0, Busy}, 32'd1);
        wait_done(n);
        chk("first_edge_latency", n, 32'd33);
        check_result("first_edge");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: Start  input  1  request; sampled only in IDLE.
REQ-004 SHALL have port: In1  input  32  dividend; captured on accepted Start.
REQ-005 SHALL have port: In2  input  32  divisor; captured on accepted Start.
REQ-006 SHALL have port: S  input  1  flag enable; captured on accepted Start.
REQ-007 SHALL have port: Quot  output  32  quotient.
REQ-008 SHALL have port: Rem  output  32  remainder.
REQ-009 SHALL have port: Busy  output  1  high from the cycle after an accepted Start through the Done cycle, inclusive.
REQ-010 SHALL have port: Done  output  1  one-cycle pulse marking a valid result.
REQ-011 SHALL have port: Flags  output  4  {N,Z,C,V} for the result.

Function
REQ-012 SHALL implement states IDLE, RUN, DONE; IDLE->RUN on Start (divisor nonzero); IDLE->DONE on Start (divisor zero); RUN->DONE after exactly 32 iterations; DONE->IDLE unconditionally.
REQ-013 SHALL, for nonzero divisor, assert Done exactly 33 cycles after the Start-sampling edge; divide-by-zero asserts Done 1 cycle after.
REQ-014 SHALL run one shift/subtract (restoring) iteration per RUN cycle on magnitudes, with a 33-bit partial remainder; the 5-bit iteration counter counts 0..31.
REQ-015 SHALL ignore Start while Busy; captured operands are not disturbed.
REQ-016 SHALL truncate the quotient toward zero; the remainder takes the dividend's sign; Quot*In2+Rem==In1 for every non-exceptional case.
REQ-017 SHALL, on divisor zero, return Quot=32'hFFFFFFFF, Rem=In1, and V=1.
REQ-018 SHALL, on 32'h80000000 / 32'hFFFFFFFF (signed), return Quot=32'h80000000, Rem=0, and V=1.
REQ-019 SHALL compute flags as: N=Quot[31], Z=(Quot==0), C=(Rem!=0), V=exception per REQ-017/REQ-018.
REQ-020 SHALL drive Flags=4'b0000 when the captured S is 0.
REQ-021 SHALL update Quot/Rem/Flags only in the Done cycle and hold them until the next Done.

Reset
REQ-022 SHALL, on rst_n low, immediately force IDLE, Quot=0, Rem=0, Flags=0, Busy=0, Done=0, and counter=0.
REQ-023 SHALL abort an operation in progress when reset is applied mid-operation; no Done follows release.
REQ-024 SHALL accept Start on the first rising edge after rst_n deasserts.

Configuration
REQ-025 SHALL, with macro DIVIDER_SIGNED_EN defined, treat In1/In2 as two's-complement and apply REQ-016 and REQ-018.
REQ-026 SHALL, without DIVIDER_SIGNED_EN, treat In1/In2 as unsigned; REQ-018 never applies and N=Quot[31].

Verification
REQ-027 SHALL cover: 100/7 with S=1 -> Done at cycle 33, Quot=14, Rem=2, Flags=4'b0010.
REQ-028 SHALL cover (signed): -100/7 -> Quot=32'hFFFFFFF2, Rem=32'hFFFFFFFE, Flags=4'b1010.
REQ-029 SHALL cover: 5/0 -> Done next cycle, Quot=32'hFFFFFFFF, Rem=5, V=1.
REQ-030 SHALL cover (signed): 32'h80000000/32'hFFFFFFFF -> Quot=32'h80000000, Rem=0, Flags=4'b1001.
REQ-031 SHALL cover: 7/7 with S=0 -> Quot=1, Rem=0, Flags=4'b0000.
REQ-032 SHALL cover: Start 9/3, then Start 8/2 at cycle 10, then reset at cycle 20 -> second Start ignored; no Done; Busy=0 and outputs 0 immediately.
